xbar_rsp_router: RTL and testbench
==================================

# xbar_rsp_router

Return-path companion for the stream crossbar. It sits on one crossbar output, between the crossbar and the downstream memory or unit port. The forward request passes through unchanged, and the block records each accepted request's `sel_out` (the originating input index) in an in-order tag queue. Returning in-order responses are steered back to that originating input, which lets a single-ported consumer serve many crossbar inputs without carrying source tags.

## Interface
Parameters:
- `NUM_INPUTS`, 4: number of crossbar inputs, which is also the number of response lanes; must be ≥ 1.
- `DATAW`, 4: request payload width.
- `RSP_DATAW`, 4: response payload width.
- `QUEUE_SIZE`, 4: maximum outstanding requests; must be a power of 2 and ≥ 2.
- `IN_WIDTH`, `LOG2UP(NUM_INPUTS)`: source-index width.
- `CNT_WIDTH`, `CLOG2(QUEUE_SIZE+1)`: width of the occupancy counter.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req_valid_in` in 1: request from the crossbar output.
- `req_data_in` in DATAW: request payload.
- `req_sel_in` in IN_WIDTH: originating input index, taken from the crossbar's `sel_out`.
- `req_ready_in` out 1: request accept.
- `req_valid_out` out 1: request to the downstream consumer.
- `req_data_out` out DATAW: request payload, forwarded unchanged.
- `req_ready_out` in 1: downstream request accept.
- `rsp_valid_in` in 1: response from downstream, returned in request order.
- `rsp_data_in` in RSP_DATAW: response payload.
- `rsp_ready_in` out 1: response accept.
- `rsp_valid_out` out NUM_INPUTS: one-hot per-input response valid.
- `rsp_data_out` out NUM_INPUTS×RSP_DATAW: response payload.
- `rsp_ready_out` in NUM_INPUTS: per-input response ready.
- `pending` out CNT_WIDTH: outstanding request count.
- `full` out 1: tag queue full.
- `empty` out 1: tag queue empty.

## Operation
Request path:
- `req_valid_out = req_valid_in && !full`.
- `req_ready_in = req_ready_out && !full`.
- `req_data_out = req_data_in`.
- A request fires when `req_valid_in && req_ready_in`. On fire, `req_sel_in` is written at the write pointer.

Response path:
- `head` is the tag at the read pointer.
- `rsp_valid_out[i] = rsp_valid_in && !empty && (head == i)`.
- `rsp_data_out[i] = rsp_data_in` for all i (broadcast).
- `rsp_ready_in = !empty && rsp_ready_out[head]`.
- A response fires when `rsp_valid_in && rsp_ready_in`; on fire the read pointer advances.

Tag queue:
- Read and write pointers are `LOG2(QUEUE_SIZE)` bits and wrap naturally.
- `pending` is +1 on request fire only, −1 on response fire only, and unchanged when both fire in the same cycle.
- `full = (pending == QUEUE_SIZE)`; `empty = (pending == 0)`.

Boundary conditions:
- **Full:** new requests stall. This holds even if a response pops in the same cycle; there is no same-cycle slot reuse, so there is no combinational path from the response side to `req_ready_in`.
- **Empty:** a response is not accepted (`rsp_ready_in = 0`). A tag written in cycle N is not visible as `head` until cycle N+1, so there is no request-to-response bypass.
- **Simultaneous push/pop at intermediate occupancy:** both take effect and `pending` is unchanged.
- **Reset mid-operation:** all queued tags are discarded. Responses to those requests that arrive after reset stall, because the queue is empty; flushing them is the system's responsibility.
- **`req_sel_in >= NUM_INPUTS`:** illegal. Checked by a simulation assertion on request fire.
- **`rsp_valid_in` while empty:** legal; it stalls.
- **`NUM_INPUTS == 1`:** `head` is ignored and `rsp_valid_out[0] = rsp_valid_in && !empty`.

## Timing
- Reset values:
  - `pending = 0`, `empty = 1`, `full = 0`, pointers = 0.
  - `req_valid_out = 0` if `req_valid_in` is low; `rsp_valid_out = 0`; `rsp_ready_in = 0`.
- Request latency is 0 cycles (combinational pass-through, gated only by `full`).
- Minimum request-fire to response-accept: 1 cycle.
- Response steering is combinational from registered `head`, with no added latency.
- Sustained throughput is 1 request and 1 response per cycle when 0 < `pending` < `QUEUE_SIZE`.
- Valid/ready rules:
  - A source holds valid and data stable until fire.
  - `rsp_valid_out` never depends on `rsp_ready_out` of the same lane.
  - `req_valid_out` does not depend on `req_ready_out`.

## Structure
- Tag storage and pointer/counter logic go in sub-module `xbar_tag_fifo`: DATAW=IN_WIDTH, SIZE=QUEUE_SIZE, registered outputs `full`/`empty`/`size`, and read data from the read pointer.
- The shared package defines `XBAR_TAG_WIDTH(n) = LOG2UP(n)` and the pending-counter width macro, so the crossbar, router and perf counters agree on widths.
- Everything else is top-level glue.

## Test plan
1. Reset, then drive `rsp_valid_in=1` with no requests → `rsp_ready_in=0`, `rsp_valid_out=0`, `pending=0`, `empty=1`.
2. Fire requests with sel 2, 0, 3 (NUM_INPUTS=4), then return responses 0xA, 0xB, 0xC → `rsp_valid_out` = 0100, 0001, 1000 in order with matching data; `pending` goes 3→0.
3. QUEUE_SIZE=4: fire 4 requests, hold `req_valid_in` → `full=1`, `req_ready_in=0`, `req_valid_out=0`. Return one response and fire one request in the same cycle → the request stalls that cycle and fires the next.
4. `pending=2`: request fire and response fire in the same cycle → `pending` stays 2 and the tag order is preserved.
5. Head tag = 1 with `rsp_ready_out[1]=0`, other lanes ready → `rsp_ready_in=0`. Raise `rsp_ready_out[1]` → the response fires on lane 1 only.
6. Assert `reset` with `pending=3` → the next cycle shows `pending=0`, `empty=1`. A following request with sel 1 plus a response routes to lane 1.

Source files
------------

// File: rtl/xbar_rsp_router_pkg.sv
// Shared width helpers for the stream crossbar, its response router and the
// perf counters, so every block derives tag and occupancy widths identically.
package xbar_rsp_router_pkg;

  // Index width that stays at least one bit wide, even for a single input.
  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a source tag that identifies one of n crossbar inputs.
  function automatic int xbar_tag_width(input int n);
    return log2up(n);
  endfunction

  // Width of an occupancy counter that must be able to hold the value q.
  function automatic int xbar_cnt_width(input int q);
    return $clog2(q + 1);
  endfunction

endpackage

// File: rtl/xbar_tag_fifo.sv
// In-order tag queue. Holds the source index of every outstanding request.
// Status outputs come straight from flops. The read data is a direct read of
// the head slot, so a tag written in one cycle cannot be read until the next.
// The caller must not push while full and must not pop while empty.
module xbar_tag_fifo
  import xbar_rsp_router_pkg::*;
#(
  parameter int DATAW     = 2,
  parameter int SIZE      = 4,
  parameter int CNT_WIDTH = xbar_cnt_width(SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATAW-1:0]     wr_data,
  output logic [DATAW-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_WIDTH-1:0] size
);

  localparam int PTRW = $clog2(SIZE);

  logic [DATAW-1:0]     mem [SIZE];
  logic [PTRW-1:0]      wr_ptr;
  logic [PTRW-1:0]      rd_ptr;
  logic [CNT_WIDTH-1:0] size_next;

  // Next occupancy: a simultaneous push and pop leaves it unchanged.
  always_comb begin
    size_next = size;
    if (push && !pop) begin
      size_next = size + CNT_WIDTH'(1);
    end else if (pop && !push) begin
      size_next = size - CNT_WIDTH'(1);
    end
  end

  // Pointers, counter and registered full/empty flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      size   <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTRW'(1);
      if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
      size  <= size_next;
      full  <= (size_next == CNT_WIDTH'(SIZE));
      empty <= (size_next == '0);
    end
  end

  // Tag storage. It has no reset: resetting the pointers discards the tags.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/xbar_rsp_router.sv
// Return-path router for one crossbar output. Requests pass through
// unchanged, gated only by the tag queue being full. The source index of each
// accepted request is queued. In-order responses are steered back to the input
// whose tag is at the head of the queue.
module xbar_rsp_router
  import xbar_rsp_router_pkg::*;
#(
  parameter int NUM_INPUTS = 4,
  parameter int DATAW      = 4,
  parameter int RSP_DATAW  = 4,
  parameter int QUEUE_SIZE = 4,
  parameter int IN_WIDTH   = xbar_tag_width(NUM_INPUTS),
  parameter int CNT_WIDTH  = xbar_cnt_width(QUEUE_SIZE)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            req_valid_in,
  input  logic [DATAW-1:0]                req_data_in,
  input  logic [IN_WIDTH-1:0]             req_sel_in,
  output logic                            req_ready_in,
  output logic                            req_valid_out,
  output logic [DATAW-1:0]                req_data_out,
  input  logic                            req_ready_out,
  input  logic                            rsp_valid_in,
  input  logic [RSP_DATAW-1:0]            rsp_data_in,
  output logic                            rsp_ready_in,
  output logic [NUM_INPUTS-1:0]           rsp_valid_out,
  output logic [NUM_INPUTS*RSP_DATAW-1:0] rsp_data_out,
  input  logic [NUM_INPUTS-1:0]           rsp_ready_out,
  output logic [CNT_WIDTH-1:0]            pending,
  output logic                            full,
  output logic                            empty
);

  logic                push;
  logic                pop;
  logic                lane_ready;
  logic [IN_WIDTH-1:0] head;

  // The full flag is registered, so a pop in the same cycle cannot free a
  // slot for the request. This keeps the response side out of req_ready_in.
  assign req_valid_out = req_valid_in && !full;
  assign req_ready_in  = req_ready_out && !full;
  assign req_data_out  = req_data_in;
  assign push          = req_valid_in && req_ready_in;

  xbar_tag_fifo #(
    .DATAW     (IN_WIDTH),
    .SIZE      (QUEUE_SIZE),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (req_sel_in),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .size    (pending)
  );

  // Steer the response to the lane named by the head tag. The lane's valid
  // never looks at that lane's ready.
  always_comb begin
    lane_ready    = 1'b0;
    rsp_valid_out = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (NUM_INPUTS == 1 || head == IN_WIDTH'(i)) begin
        lane_ready       = rsp_ready_out[i];
        rsp_valid_out[i] = rsp_valid_in && !empty;
      end
    end
  end

  assign rsp_ready_in = !empty && lane_ready;
  assign pop          = rsp_valid_in && rsp_ready_in;
  assign rsp_data_out = {NUM_INPUTS{rsp_data_in}};

  // A request must name an existing crossbar input.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      assert (int'(req_sel_in) < NUM_INPUTS);
    end
  end

endmodule

// File: tb/tb_xbar_rsp_router.sv
// Bench for xbar_rsp_router with NUM_INPUTS=4 and QUEUE_SIZE=4. A queue of
// outstanding source tags predicts every output on every cycle. Directed steps
// cover the corner cases, followed by a randomized run.
module tb_xbar_rsp_router;

  localparam int NI = 4;
  localparam int QS = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_in;
  logic [3:0]  req_data_in;
  logic [1:0]  req_sel_in;
  logic        req_ready_in;
  logic        req_valid_out;
  logic [3:0]  req_data_out;
  logic        req_ready_out;
  logic        rsp_valid_in;
  logic [3:0]  rsp_data_in;
  logic        rsp_ready_in;
  logic [3:0]  rsp_valid_out;
  logic [15:0] rsp_data_out;
  logic [3:0]  rsp_ready_out;
  logic [2:0]  pending;
  logic        full;
  logic        empty;

  int n_checks = 0;
  int n_pass   = 0;
  int q[$];
  bit push_m;
  bit pop_m;

  xbar_rsp_router #(
    .NUM_INPUTS (NI),
    .DATAW      (4),
    .RSP_DATAW  (4),
    .QUEUE_SIZE (QS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid_in  (req_valid_in),
    .req_data_in   (req_data_in),
    .req_sel_in    (req_sel_in),
    .req_ready_in  (req_ready_in),
    .req_valid_out (req_valid_out),
    .req_data_out  (req_data_out),
    .req_ready_out (req_ready_out),
    .rsp_valid_in  (rsp_valid_in),
    .rsp_data_in   (rsp_data_in),
    .rsp_ready_in  (rsp_ready_in),
    .rsp_valid_out (rsp_valid_out),
    .rsp_data_out  (rsp_data_out),
    .rsp_ready_out (rsp_ready_out),
    .pending       (pending),
    .full          (full),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Predict all outputs from the queue of outstanding tags.
  task automatic check_all();
    int  n;
    bit  f;
    bit  e;
    int  hd;
    n  = q.size();
    f  = (n == QS);
    e  = (n == 0);
    hd = e ? 0 : q[0];
    chk("pending", 32'(pending), n);
    chk("full", 32'(full), 32'(f));
    chk("empty", 32'(empty), 32'(e));
    chk("req_valid_out", 32'(req_valid_out), 32'(req_valid_in && !f));
    chk("req_ready_in", 32'(req_ready_in), 32'(req_ready_out && !f));
    chk("req_data_out", 32'(req_data_out), 32'(req_data_in));
    chk("rsp_valid_out", 32'(rsp_valid_out), (rsp_valid_in && !e) ? (32'd1 << hd) : 32'd0);
    chk("rsp_ready_in", 32'(rsp_ready_in), 32'(!e && rsp_ready_out[hd]));
    chk("rsp_data_out", 32'(rsp_data_out), 32'({4{rsp_data_in}}));
    push_m = req_valid_in && req_ready_out && !f;
    pop_m  = rsp_valid_in && !e && rsp_ready_out[hd];
  endtask

  task automatic do_cycle();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (reset) begin
      q.delete();
    end else begin
      if (pop_m)  void'(q.pop_front());
      if (push_m) q.push_back(int'(req_sel_in));
    end
    #1;
  endtask

  task automatic push_one(input logic [1:0] sel);
    req_valid_in  = 1'b1;
    req_ready_out = 1'b1;
    req_sel_in    = sel;
    req_data_in   = 4'(sel) + 4'h5;
    do_cycle();
    req_valid_in  = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_valid_in = 1'b0; req_data_in = '0; req_sel_in = '0; req_ready_out = 1'b0;
    rsp_valid_in = 1'b0; rsp_data_in = '0; rsp_ready_out = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: response with nothing outstanding stalls
    rsp_valid_in = 1'b1; rsp_ready_out = 4'hF; rsp_data_in = 4'h9;
    #1;
    chk("t1_rsp_ready_in", 32'(rsp_ready_in), 0);
    chk("t1_rsp_valid_out", 32'(rsp_valid_out), 0);
    do_cycle(); do_cycle();
    chk("t1_pending", 32'(pending), 0);
    chk("t1_empty", 32'(empty), 1);
    rsp_valid_in = 1'b0;

    // 2: sel 2,0,3 then responses A,B,C routed in order
    push_one(2'd2); push_one(2'd0); push_one(2'd3);
    chk("t2_pending3", 32'(pending), 3);
    rsp_valid_in = 1'b1;
    rsp_data_in = 4'hA; #1 chk("t2_lane_a", 32'(rsp_valid_out), 32'b0100); do_cycle();
    rsp_data_in = 4'hB; #1 chk("t2_lane_b", 32'(rsp_valid_out), 32'b0001); do_cycle();
    rsp_data_in = 4'hC; #1 chk("t2_lane_c", 32'(rsp_valid_out), 32'b1000);
    chk("t2_data_c", 32'(rsp_data_out), 32'hCCCC);
    do_cycle();
    chk("t2_pending0", 32'(pending), 0);
    rsp_valid_in = 1'b0;

    // 3: fill, then a pop does not free a slot in the same cycle
    req_valid_in = 1'b1; req_ready_out = 1'b1;
    for (int i = 0; i < QS; i++) begin
      req_sel_in = 2'(i); req_data_in = 4'(i);
      do_cycle();
    end
    chk("t3_full", 32'(full), 1);
    chk("t3_req_ready_in", 32'(req_ready_in), 0);
    chk("t3_req_valid_out", 32'(req_valid_out), 0);
    req_sel_in = 2'd3;
    do_cycle();
    rsp_valid_in = 1'b1;
    do_cycle();
    chk("t3_after_pop", 32'(pending), 3);
    rsp_valid_in = 1'b0;
    do_cycle();
    chk("t3_refill", 32'(pending), 4);
    req_valid_in = 1'b0; rsp_valid_in = 1'b1;
    repeat (QS) do_cycle();
    chk("t3_drained", 32'(pending), 0);
    rsp_valid_in = 1'b0;

    // 4: simultaneous push and pop at pending=2
    push_one(2'd1); push_one(2'd2);
    req_valid_in = 1'b1; req_sel_in = 2'd3; rsp_valid_in = 1'b1;
    do_cycle();
    chk("t4_pending", 32'(pending), 2);
    req_valid_in = 1'b0;
    #1 chk("t4_order", 32'(rsp_valid_out), 32'b0100);
    repeat (2) do_cycle();
    rsp_valid_in = 1'b0;

    // 5: head lane not ready blocks the response
    push_one(2'd1);
    rsp_valid_in = 1'b1; rsp_ready_out = 4'b1101;
    #1;
    chk("t5_blocked", 32'(rsp_ready_in), 0);
    chk("t5_valid_lane1", 32'(rsp_valid_out), 32'b0010);
    do_cycle();
    chk("t5_held", 32'(pending), 1);
    rsp_ready_out = 4'hF;
    #1 chk("t5_ready", 32'(rsp_ready_in), 1);
    do_cycle();
    chk("t5_popped", 32'(pending), 0);
    rsp_valid_in = 1'b0;

    // 6: reset with three tags outstanding
    push_one(2'd0); push_one(2'd2); push_one(2'd3);
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
    chk("t6_pending", 32'(pending), 0);
    chk("t6_empty", 32'(empty), 1);
    push_one(2'd1);
    rsp_valid_in = 1'b1;
    #1 chk("t6_lane1", 32'(rsp_valid_out), 32'b0010);
    do_cycle();
    rsp_valid_in = 1'b0;

    // Randomized traffic, biased to reach both full and empty.
    for (int c = 0; c < 800; c++) begin
      int bias;
      bias = (c / 100) % 2;
      req_valid_in  = ($urandom_range(0, 9) < (bias ? 8 : 3));
      req_ready_out = ($urandom_range(0, 3) != 0);
      req_sel_in    = 2'($urandom_range(0, NI - 1));
      req_data_in   = 4'($urandom);
      rsp_valid_in  = ($urandom_range(0, 9) < (bias ? 3 : 8));
      rsp_data_in   = 4'($urandom);
      rsp_ready_out = 4'($urandom) | 4'($urandom);
      reset         = ($urandom_range(0, 199) == 0);
      do_cycle();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
